// File: rtl/truth_table_checker.sv
// Sweeps every input combination of a small combinational DUT, holds each vector
// SETTLE+1 cycles, samples y and scores it against the EXPECTED truth table.
module truth_table_checker #(
    parameter int                 N_IN     = 4,
    parameter logic [2**N_IN-1:0] EXPECTED = '0,
    parameter int                 SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                y,
    output logic [N_IN-1:0]     vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       err_count,
    output logic [2**N_IN-1:0]  fail_mask,
    output logic [N_IN-1:0]     first_fail,
    output logic                fail_valid
);

    // state | meaning
    // IDLE  | waiting for start, no results yet
    // HOLD  | driving vec, counting settle cycles, sampling on the last one
    // DONE  | sweep finished, results and vec held until the next start
    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t                state_q, state_d;
    logic [N_IN-1:0]       vec_q, vec_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [N_IN:0]         err_q, err_d;
    logic [2**N_IN-1:0]    mask_q, mask_d;
    logic [N_IN-1:0]       ff_q, ff_d;
    logic                  fv_q, fv_d;

    logic                  mismatch;
    logic [N_IN:0]         err_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            mask_q  <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        mask_d   = mask_q;
        ff_d     = ff_q;
        fv_d     = fv_q;
        mismatch = (y != EXPECTED[vec_q]);
        // Count including this row so pass reflects the final row on the last edge.
        err_inc  = err_q + (N_IN+1)'(mismatch);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = HOLD;
                    vec_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    mask_d  = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_q != 4'(SETTLE)) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    if (mismatch) begin
                        mask_d[vec_q] = 1'b1;
                        err_d         = err_inc;
                        if (!fv_q) begin
                            ff_d = vec_q;
                            fv_d = 1'b1;
                        end
                    end
                    if (vec_q != {N_IN{1'b1}}) begin
                        vec_d = vec_q + 1'b1;
                        cnt_d = '0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_inc == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign vec        = vec_q;
    assign busy       = (state_q == HOLD);
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_mask  = mask_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking response end of the lab's exhaustive truth-table benches, built as synthesizable hardware. It walks every input combination of a combinational gate-level or operator-level module, lets each vector settle, and samples the module's output. It compares each sample against a parameterized expected truth table and reports pass/fail, a mismatch count, a per-row failure mask and the first failing row. It sits beside a lab DUT, driving the DUT's inputs from `vec` and taking its output on `y`.

## Interface

Parameters:
- `N_IN`, default 4: number of DUT inputs; legal range 1..5. `vec[N_IN-1]` is the leftmost truth-table column (A).
- `EXPECTED`, default 16'h0000: expected output table, width 2**N_IN. Bit i is the required `y` when `vec == i`.
- `SETTLE`, default 1: extra cycles each vector is held before sampling; legal range 0..15.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request a full sweep; accepted only in IDLE or DONE.
- `y`, input, 1: DUT output under test.
- `vec`, output, N_IN: current input vector driven to the DUT.
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: one-cycle pulse after the last row is sampled.
- `pass`, output, 1: high when the last completed sweep had zero mismatches. Valid from `done` until the next accepted `start`.
- `err_count`, output, N_IN+1: number of mismatching rows, range 0..2**N_IN.
- `fail_mask`, output, 2**N_IN: bit i set when row i mismatched.
- `first_fail`, output, N_IN: lowest mismatching row index.
- `fail_valid`, output, 1: `first_fail` holds a real row (at least one mismatch seen).

## Operation

- States: IDLE, HOLD, DONE.
- Reset values, forced immediately and asynchronously while `rst_n` = 0:
  - state = IDLE
  - `vec` = 0, `busy` = 0, `done` = 0, `pass` = 0
  - `err_count` = 0, `fail_mask` = 0, `first_fail` = 0, `fail_valid` = 0
- IDLE or DONE with `start` = 1 at an edge:
  - `vec` <= 0, hold counter <= 0, `busy` <= 1
  - all results cleared (`pass` <= 0, `err_count` <= 0, `fail_mask` <= 0, `first_fail` <= 0, `fail_valid` <= 0)
  - go to HOLD.
- HOLD, hold counter < SETTLE: counter increments; `vec` unchanged.
- HOLD, hold counter == SETTLE: this is the sample edge.
  - If `y != EXPECTED[vec]`: set `fail_mask[vec]`, increment `err_count`. If `fail_valid` = 0, load `first_fail` <= `vec` and set `fail_valid` <= 1.
  - If `vec` < 2**N_IN-1: `vec` increments, counter <= 0.
  - Else: go to DONE, `busy` <= 0, `done` <= 1, and `pass` <= 1 exactly when the final `err_count` is 0 (including the last row's result).
- DONE: `done` falls after one cycle. Results and `vec` (all ones) hold until the next `start`.
- `start` while `busy` is ignored; the sweep is not restarted or disturbed.
- Arithmetic:
  - `err_count` never wraps; its width holds the all-rows-fail case.
  - `vec` wraps only by returning to 0 on a new `start`.
- `rst_n` low mid-sweep aborts the sweep. Nothing is retained; the next sweep needs a fresh `start`.

## Timing

- Each vector is driven for exactly SETTLE+1 cycles; `y` is sampled on the last rising edge of that window.
- The start edge is edge 0. The sample for row i occurs at edge (i+1)·(SETTLE+1).
- `done` is high in the cycle following the final sample edge. Sweep latency is 2**N_IN·(SETTLE+1) cycles from the start edge to `done` high.
- Results update on the same edge as each sample. `pass` is asserted together with `done`.
- `start` asserted in the same cycle as `done` is accepted: results clear and a new sweep begins.
- The DUT path from `vec` to `y` must settle within SETTLE+1 cycles; `y` is treated as registered-domain input (no synchronizer).

## Test plan

- N_IN=3, SETTLE=1, EXPECTED=8'hE8 (3-input majority), correct majority DUT, `start` pulsed -> `done` at 16 cycles, `pass`=1, `err_count`=0, `fail_mask`=8'h00, `fail_valid`=0.
- Same config, `y` tied 0 -> `err_count`=4, `fail_mask`=8'hE8, `first_fail`=3, `fail_valid`=1, `pass`=0.
- Same config, inverted majority DUT -> `err_count`=8 (full-scale, no wrap), `fail_mask`=8'hFF, `first_fail`=0.
- `start` re-pulsed at vector 2 mid-sweep -> ignored, `done` still at cycle 16. Then a second `start` in the `done` cycle -> results cleared and `vec`=0 on the next cycle.
- `rst_n` pulsed low asynchronously while `vec`=4 -> all outputs 0 before the next edge. A new `start` sweeps from `vec`=0 with correct totals.
- N_IN=4, SETTLE=3, EXPECTED=16'h8000 (4-input AND), correct AND DUT -> each `vec` held 4 cycles, `done` at cycle 64, `pass`=1.
